aiken_counter_ctrl: RTL and testbench

Sequencing controller for a multi-digit reversible decade counter in Aiken code: 0..4 = 0000..0100, 5..9 = 1011..1111.
- Accepts count commands over a valid/ready handshake and applies them one step per clock.
- Ripples carry/borrow across DIGITS Aiken digits.
- Reports completion and wrap-around.
- Sits between a command source (buttons/debouncer or host FSM) and the display/decoder logic.

---
 rtl/aiken_counter_ctrl_pkg.sv | 54 +++++
 rtl/aiken_counter_ctrl_digit.sv | 33 +++
 rtl/aiken_counter.sv | 115 +++++++++++
 tb/tb_aiken_counter_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/aiken_counter_ctrl_pkg.sv
// Shared definitions for the Aiken-code decade counter: command opcodes,
// FSM states and the Aiken sequence successor/predecessor functions.
package aiken_pkg;

    typedef enum logic [1:0] {
        OP_UP    = 2'b00,
        OP_DOWN  = 2'b01,
        OP_CLEAR = 2'b10,
        OP_SET   = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIN  = 2'b10
    } state_t;

    localparam logic [3:0] AIKEN_0 = 4'b0000;
    localparam logic [3:0] AIKEN_9 = 4'b1111;

    // Codes 0101..1010 never occur in Aiken; they fall back to 0000.
    function automatic logic [3:0] aikenNextUp(input logic [3:0] q);
        case (q)
            4'b0000: aikenNextUp = 4'b0001;
            4'b0001: aikenNextUp = 4'b0010;
            4'b0010: aikenNextUp = 4'b0011;
            4'b0011: aikenNextUp = 4'b0100;
            4'b0100: aikenNextUp = 4'b1011;
            4'b1011: aikenNextUp = 4'b1100;
            4'b1100: aikenNextUp = 4'b1101;
            4'b1101: aikenNextUp = 4'b1110;
            4'b1110: aikenNextUp = 4'b1111;
            4'b1111: aikenNextUp = 4'b0000;
            default: aikenNextUp = 4'b0000;
        endcase
    endfunction

    function automatic logic [3:0] aikenNextDown(input logic [3:0] q);
        case (q)
            4'b0000: aikenNextDown = 4'b1111;
            4'b1111: aikenNextDown = 4'b1110;
            4'b1110: aikenNextDown = 4'b1101;
            4'b1101: aikenNextDown = 4'b1100;
            4'b1100: aikenNextDown = 4'b1011;
            4'b1011: aikenNextDown = 4'b0100;
            4'b0100: aikenNextDown = 4'b0011;
            4'b0011: aikenNextDown = 4'b0010;
            4'b0010: aikenNextDown = 4'b0001;
            4'b0001: aikenNextDown = 4'b0000;
            default: aikenNextDown = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/aiken_counter_ctrl_digit.sv
// One reversible Aiken decade digit with parallel load and end-of-range
// flags that feed the ripple enable chain.
module aiken_digit (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    input  logic       DIR,
    input  logic       LOAD,
    input  logic [3:0] LOAD_VAL,
    output logic [3:0] Q,
    output logic       AT_MAX,
    output logic       AT_MIN
);
    import aiken_pkg::*;

    logic [3:0] r_q;

    // LOAD wins over stepping; DIR=1 counts down.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_q <= AIKEN_0;
        end else if (LOAD) begin
            r_q <= LOAD_VAL;
        end else if (EN) begin
            r_q <= DIR ? aikenNextDown(r_q) : aikenNextUp(r_q);
        end
    end

    assign Q      = r_q;
    assign AT_MAX = (r_q == AIKEN_9);
    assign AT_MIN = (r_q == AIKEN_0);

endmodule

// File: rtl/aiken_counter.sv
// Top-level sequencing controller: command handshake, step counter,
// ripple enable chain across the digits, and DONE/WRAP pulse generation.
module aiken_counter_ctrl #(
    parameter int DIGITS = 4,
    parameter int STEP_W = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    input  logic [1:0]            CMD_OP,
    input  logic [STEP_W-1:0]     CMD_STEPS,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  WRAP,
    output logic [4*DIGITS-1:0]   DIGITS_OUT
);
    import aiken_pkg::*;

    state_t              r_state;
    op_t                 r_op;
    logic [STEP_W-1:0]   r_steps;
    logic                r_done;
    logic                r_wrap;

    op_t                 w_cmdOp;
    logic                w_accept;
    logic                w_step;
    logic                w_dir;
    logic                w_load;
    logic                w_immediate;
    logic [3:0]          w_loadVal;
    logic [DIGITS:0]     w_carry;
    logic [DIGITS-1:0]   w_atMax;
    logic [DIGITS-1:0]   w_atMin;
    logic [DIGITS-1:0]   w_en;

    assign w_cmdOp     = op_t'(CMD_OP);
    assign CMD_READY   = (r_state == IDLE) && !RST;
    assign BUSY        = (r_state == RUN);
    assign w_accept    = CMD_VALID && CMD_READY;
    assign w_step      = (r_state == RUN);
    assign w_dir       = (r_op == OP_DOWN);
    assign w_load      = w_accept && ((w_cmdOp == OP_CLEAR) || (w_cmdOp == OP_SET));
    assign w_loadVal   = (w_cmdOp == OP_SET) ? AIKEN_9 : AIKEN_0;
    assign w_immediate = (w_cmdOp == OP_CLEAR) || (w_cmdOp == OP_SET) ||
                         (CMD_STEPS == '0);

    // w_carry[i] is high when every digit below i sits at the end of its
    // range in the counting direction; w_carry[DIGITS] marks a full wrap.
    assign w_carry[0] = 1'b1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        assign w_carry[g+1] = w_carry[g] && (w_dir ? w_atMin[g] : w_atMax[g]);
        assign w_en[g]      = w_step && w_carry[g];

        aiken_digit u_digit (
            .CLK      (CLK),
            .RST      (RST),
            .EN       (w_en[g]),
            .DIR      (w_dir),
            .LOAD     (w_load),
            .LOAD_VAL (w_loadVal),
            .Q        (DIGITS_OUT[4*g +: 4]),
            .AT_MAX   (w_atMax[g]),
            .AT_MIN   (w_atMin[g])
        );
    end

    // DONE and WRAP are single-cycle pulses, cleared every edge by default.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
            r_op    <= OP_UP;
            r_steps <= '0;
            r_done  <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_wrap <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op    <= w_cmdOp;
                        r_steps <= CMD_STEPS;
                        if (w_immediate) begin
                            r_state <= FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    r_steps <= r_steps - 1'b1;
                    r_wrap  <= w_carry[DIGITS];
                    if (r_steps == STEP_W'(1)) begin
                        r_state <= FIN;
                        r_done  <= 1'b1;
                    end
                end
                FIN: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign DONE = r_done;
    assign WRAP = r_wrap;

endmodule

// File: tb/tb_aiken_counter_ctrl.sv
// Directed self-checking bench for aiken_counter_ctrl with hand-computed
// Aiken digit values for each command.
module tb_aiken_counter_ctrl;

    logic        CLK;
    logic        RST;
    logic        CMD_VALID;
    logic        CMD_READY;
    logic [1:0]  CMD_OP;
    logic [7:0]  CMD_STEPS;
    logic        BUSY;
    logic        DONE;
    logic        WRAP;
    logic [15:0] DIGITS_OUT;

    int total = 0;
    int bad   = 0;

    aiken_counter_ctrl #(.DIGITS(4), .STEP_W(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .CMD_VALID  (CMD_VALID),
        .CMD_READY  (CMD_READY),
        .CMD_OP     (CMD_OP),
        .CMD_STEPS  (CMD_STEPS),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .WRAP       (WRAP),
        .DIGITS_OUT (DIGITS_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance to just after the next rising edge so outputs are stable.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Issues one command, scrambles the inputs after accept, runs to IDLE
    // and checks final digits, busy length, DONE timing and WRAP count.
    task automatic applyStimulus(input string tag, input logic [1:0] op,
                                 input logic [7:0] steps, input logic [15:0] expDigits,
                                 input int expBusy, input int expDoneAt,
                                 input int expWrap);
        int busyN;
        int doneN;
        int wrapN;
        int doneAt;
        int cyc;
        CMD_VALID = 1'b1;
        CMD_OP    = op;
        CMD_STEPS = steps;
        tick();
        CMD_VALID = 1'b0;
        CMD_OP    = ~op;
        CMD_STEPS = 8'hFF;
        busyN  = 0;
        doneN  = 0;
        wrapN  = 0;
        doneAt = -1;
        cyc    = 0;
        while (CMD_READY !== 1'b1 && cyc < 300) begin
            if (BUSY === 1'b1) busyN++;
            if (DONE === 1'b1) begin
                doneN++;
                if (doneAt < 0) doneAt = cyc;
            end
            if (WRAP === 1'b1) wrapN++;
            tick();
            cyc++;
        end
        checkOutput({tag, "_ready"},  {31'd0, CMD_READY}, 32'd1);
        checkOutput({tag, "_digits"}, {16'd0, DIGITS_OUT}, {16'd0, expDigits});
        checkOutput({tag, "_busy"},   busyN, expBusy);
        checkOutput({tag, "_doneN"},  doneN, 1);
        checkOutput({tag, "_doneAt"}, doneAt, expDoneAt);
        checkOutput({tag, "_wrap"},   wrapN, expWrap);
    endtask

    initial begin
        int accepts;
        int dones;
        RST       = 1'b1;
        CMD_VALID = 1'b0;
        CMD_OP    = 2'b00;
        CMD_STEPS = 8'd0;

        $display("[TB] reset");
        tick();
        tick();
        checkOutput("rst_digits", {16'd0, DIGITS_OUT}, 32'h0000);
        checkOutput("rst_ready",  {31'd0, CMD_READY}, 32'd0);
        checkOutput("rst_busy",   {31'd0, BUSY}, 32'd0);
        checkOutput("rst_done",   {31'd0, DONE}, 32'd0);
        checkOutput("rst_wrap",   {31'd0, WRAP}, 32'd0);
        RST = 1'b0;
        tick();
        checkOutput("rel_ready",  {31'd0, CMD_READY}, 32'd1);

        $display("[TB] counting and carry chain");
        applyStimulus("up5",    2'b00, 8'd5,  16'h000B, 5,  5,  0);
        applyStimulus("up45",   2'b00, 8'd45, 16'h00B0, 45, 45, 0);
        applyStimulus("down1",  2'b01, 8'd1,  16'h004F, 1,  1,  0);
        applyStimulus("up1",    2'b00, 8'd1,  16'h00B0, 1,  1,  0);

        $display("[TB] set, clear and wrap");
        applyStimulus("set",     2'b11, 8'd7, 16'hFFFF, 0, 0, 0);
        applyStimulus("upWrap",  2'b00, 8'd1, 16'h0000, 1, 1, 1);
        applyStimulus("dnWrap",  2'b01, 8'd1, 16'hFFFF, 1, 1, 1);
        applyStimulus("clear",   2'b10, 8'd3, 16'h0000, 0, 0, 0);
        applyStimulus("up0",     2'b00, 8'd0, 16'h0000, 0, 0, 0);

        $display("[TB] valid held across run");
        accepts   = 0;
        dones     = 0;
        CMD_VALID = 1'b1;
        CMD_OP    = 2'b00;
        CMD_STEPS = 8'd3;
        for (int i = 0; i < 10; i++) begin
            if (CMD_VALID === 1'b1 && CMD_READY === 1'b1) accepts++;
            if (DONE === 1'b1) dones++;
            if (i < 9) tick();
        end
        checkOutput("hold_accepts", accepts, 2);
        checkOutput("hold_dones",   dones, 2);
        checkOutput("hold_digits",  {16'd0, DIGITS_OUT}, 32'h000C);
        CMD_VALID = 1'b0;
        tick();
        checkOutput("hold_ready",   {31'd0, CMD_READY}, 32'd1);

        $display("[TB] reset during run");
        applyStimulus("clear2", 2'b10, 8'd0, 16'h0000, 0, 0, 0);
        CMD_VALID = 1'b1;
        CMD_OP    = 2'b00;
        CMD_STEPS = 8'd10;
        tick();
        CMD_VALID = 1'b0;
        tick();
        tick();
        tick();
        checkOutput("mid_digits", {16'd0, DIGITS_OUT}, 32'h0003);
        checkOutput("mid_busy",   {31'd0, BUSY}, 32'd1);
        RST = 1'b1;
        #1;
        checkOutput("abort_digits", {16'd0, DIGITS_OUT}, 32'h0000);
        checkOutput("abort_busy",   {31'd0, BUSY}, 32'd0);
        checkOutput("abort_ready",  {31'd0, CMD_READY}, 32'd0);
        checkOutput("abort_done",   {31'd0, DONE}, 32'd0);
        tick();
        checkOutput("abort_done2",  {31'd0, DONE}, 32'd0);
        RST = 1'b0;
        tick();
        checkOutput("after_ready",  {31'd0, CMD_READY}, 32'd1);
        checkOutput("after_digits", {16'd0, DIGITS_OUT}, 32'h0000);
        checkOutput("after_done",   {31'd0, DONE}, 32'd0);
        applyStimulus("up2", 2'b00, 8'd2, 16'h0002, 2, 2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
